// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: response-slot state and request control bundle.
package alu_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  localparam int ALU_ARB_MAX_REQ = 8;

  // Control fields forwarded to the ALU for the granted requester
  typedef struct packed {
    logic [2:0] comp_sel;
    logic       op_0_sel;
    logic [2:0] op_1_sel;
  } alu_ctl_t;

endpackage

// File: rtl/alu_arb_rr.sv
// Round-robin grant logic for alu_arb; only built when ALU_ARB_RR_EN is defined.
`ifdef ALU_ARB_RR_EN
module arb_rr #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic             accept_i,
  output logic             gnt_vld_o,
  output logic [IW-1:0]    gnt_idx_o
);

  logic [IW-1:0] last_q;

  // Scan from farthest to nearest so the first valid index after last_q wins
  always_comb begin
    int idx;
    idx       = 0;
    gnt_vld_o = |req_valid_i;
    gnt_idx_o = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid_i[idx]) gnt_idx_o = IW'(idx);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         last_q <= IW'(N_REQ - 1);
    else if (accept_i) last_q <= gnt_idx_o;
  end

endmodule
`endif

// File: rtl/alu_arb.sv
// Shares one combinational ALU between N_REQ requesters with a one-entry response slot.
// ALU_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int N_REQ = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  output logic [N_REQ-1:0]           req_ready_o,
  input  logic [N_REQ-1:0][2:0]      req_comp_sel_i,
  input  logic [N_REQ-1:0]           req_op_0_sel_i,
  input  logic [N_REQ-1:0][2:0]      req_op_1_sel_i,
  input  logic [N_REQ-1:0][XLEN-1:0] req_a_data_i,
  input  logic [N_REQ-1:0][XLEN-1:0] req_b_data_i,
  output logic [N_REQ-1:0]           rsp_valid_o,
  input  logic [N_REQ-1:0]           rsp_ready_i,
  output logic                       rsp_comp_o,
  output logic [XLEN-1:0]            rsp_data_o,
  output logic [2:0]                 alu_comp_sel_o,
  output logic                       alu_op_0_sel_o,
  output logic [2:0]                 alu_op_1_sel_o,
  output logic [XLEN-1:0]            alu_a_data_o,
  output logic [XLEN-1:0]            alu_b_data_o,
  input  logic                       alu_comp_i,
  input  logic [XLEN-1:0]            alu_data_i
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   own_q, own_d, gnt_idx;
  logic            gnt_vld, slot_free, accept;
  logic            comp_q;
  logic [XLEN-1:0] data_q;
  alu_ctl_t        ctl;

`ifdef ALU_ARB_RR_EN
  arb_rr #(.N_REQ(N_REQ), .IW(IW)) u_arb_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .accept_i    (accept),
    .gnt_vld_o   (gnt_vld),
    .gnt_idx_o   (gnt_idx)
  );
`else
  always_comb begin
    gnt_vld = |req_valid_i;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_valid_i[i]) gnt_idx = IW'(i);
  end
`endif

  // Owner's release frees the slot in the same cycle, giving back-to-back accepts
  assign slot_free = (state_q == EMPTY) || rsp_ready_i[own_q];
  assign accept    = gnt_vld && slot_free;

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    ctl          = '0;
    alu_a_data_o = '0;
    alu_b_data_o = '0;
    if (gnt_vld) begin
      ctl.comp_sel = req_comp_sel_i[gnt_idx];
      ctl.op_0_sel = req_op_0_sel_i[gnt_idx];
      ctl.op_1_sel = req_op_1_sel_i[gnt_idx];
      alu_a_data_o = req_a_data_i[gnt_idx];
      alu_b_data_o = req_b_data_i[gnt_idx];
    end
  end

  assign alu_comp_sel_o = ctl.comp_sel;
  assign alu_op_0_sel_o = ctl.op_0_sel;
  assign alu_op_1_sel_o = ctl.op_1_sel;

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    if (accept) begin
      state_d = FULL;
      own_d   = gnt_idx;
    end else if (state_q == FULL && rsp_ready_i[own_q]) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      own_q   <= '0;
      comp_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      if (accept) begin
        comp_q <= alu_comp_i;
        data_q <= alu_data_i;
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == FULL) rsp_valid_o[own_q] = 1'b1;
  end

  assign rsp_comp_o = comp_q;
  assign rsp_data_o = data_q;

  // A pending request must stay valid until it is accepted
  for (genvar i = 0; i < N_REQ; i++) begin : g_hold
    a_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      req_valid_i[i] && !req_ready_o[i] |=> req_valid_i[i]);
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed table-driven bench for alu_arb with a behavioural ALU model on the ALU ports.
module tb_alu_arb;

  localparam int XLEN = 32;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SLTU = 3'd3, OP_XOR = 3'd4, OP_OR = 3'd6;
  localparam logic [2:0] C_BEQ = 3'd0, C_BLT = 3'd4, C_BLTU = 3'd6;

  typedef struct packed {
    logic [2:0]  op1;
    logic        op0;
    logic [2:0]  cs;
    logic [31:0] a;
    logic [31:0] b;
  } rq_t;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  rr;
    rq_t         r0;
    rq_t         r1;
    logic [1:0]  erdy;
    logic [1:0]  evld;
    logic [31:0] edata;
    logic        ecomp;
    logic [31:0] ealu;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]            req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][2:0]       req_comp_sel, req_op_1_sel;
  logic [1:0]            req_op_0_sel;
  logic [1:0][XLEN-1:0]  req_a_data, req_b_data;
  logic                  rsp_comp, alu_op_0_sel, alu_comp;
  logic [XLEN-1:0]       rsp_data, alu_a_data, alu_b_data, alu_data;
  logic [2:0]            alu_comp_sel, alu_op_1_sel;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  rq_t  NONE, ADD57, BLT, BLTU, ORF, XORF, SUB, SLTU, A11, A100, A34, A88;

  always #5 clk = ~clk;

  alu_arb #(.XLEN(XLEN), .N_REQ(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_comp_sel_i (req_comp_sel),
    .req_op_0_sel_i (req_op_0_sel),
    .req_op_1_sel_i (req_op_1_sel),
    .req_a_data_i   (req_a_data),
    .req_b_data_i   (req_b_data),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_comp_o     (rsp_comp),
    .rsp_data_o     (rsp_data),
    .alu_comp_sel_o (alu_comp_sel),
    .alu_op_0_sel_o (alu_op_0_sel),
    .alu_op_1_sel_o (alu_op_1_sel),
    .alu_a_data_o   (alu_a_data),
    .alu_b_data_o   (alu_b_data),
    .alu_comp_i     (alu_comp),
    .alu_data_i     (alu_data)
  );

  // Behavioural ALU (RISC-V style encodings)
  always_comb begin
    alu_data = '0;
    alu_comp = 1'b0;
    case (alu_op_1_sel)
      3'd0: alu_data = alu_op_0_sel ? alu_a_data - alu_b_data : alu_a_data + alu_b_data;
      3'd1: alu_data = alu_a_data << alu_b_data[4:0];
      3'd2: alu_data = {31'd0, $signed(alu_a_data) < $signed(alu_b_data)};
      3'd3: alu_data = {31'd0, alu_a_data < alu_b_data};
      3'd4: alu_data = alu_a_data ^ alu_b_data;
      3'd5: alu_data = alu_op_0_sel ? 32'($signed(alu_a_data) >>> alu_b_data[4:0])
                                    : alu_a_data >> alu_b_data[4:0];
      3'd6: alu_data = alu_a_data | alu_b_data;
      default: alu_data = alu_a_data & alu_b_data;
    endcase
    case (alu_comp_sel)
      3'd0: alu_comp = alu_a_data == alu_b_data;
      3'd1: alu_comp = alu_a_data != alu_b_data;
      3'd4: alu_comp = $signed(alu_a_data) < $signed(alu_b_data);
      3'd5: alu_comp = $signed(alu_a_data) >= $signed(alu_b_data);
      3'd6: alu_comp = alu_a_data < alu_b_data;
      3'd7: alu_comp = alu_a_data >= alu_b_data;
      default: alu_comp = 1'b0;
    endcase
  end

  function automatic rq_t rq(input logic [2:0] op1, input logic op0, input logic [2:0] cs,
                             input logic [31:0] a, input logic [31:0] b);
    rq_t r;
    r.op1 = op1; r.op0 = op0; r.cs = cs; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic add(input logic [1:0] v, input logic [1:0] rr, input rq_t r0, input rq_t r1,
                     input logic [1:0] erdy, input logic [1:0] evld, input logic [31:0] edata,
                     input logic ecomp, input logic [31:0] ealu);
    vec_t t;
    t.v = v; t.rr = rr; t.r0 = r0; t.r1 = r1;
    t.erdy = erdy; t.evld = evld; t.edata = edata; t.ecomp = ecomp; t.ealu = ealu;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] rr, input rq_t r0, input rq_t r1);
    req_valid       = v;
    rsp_ready       = rr;
    req_op_1_sel[0] = r0.op1; req_op_0_sel[0] = r0.op0; req_comp_sel[0] = r0.cs;
    req_a_data[0]   = r0.a;   req_b_data[0]   = r0.b;
    req_op_1_sel[1] = r1.op1; req_op_0_sel[1] = r1.op0; req_comp_sel[1] = r1.cs;
    req_a_data[1]   = r1.a;   req_b_data[1]   = r1.b;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    NONE  = rq(3'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    ADD57 = rq(OP_ADD, 1'b0, C_BEQ, 32'd5, 32'd7);
    BLT   = rq(OP_ADD, 1'b0, C_BLT, 32'hFFFF_FFFF, 32'd1);
    BLTU  = rq(OP_ADD, 1'b0, C_BLTU, 32'hFFFF_FFFF, 32'd1);
    ORF   = rq(OP_OR, 1'b0, C_BEQ, 32'hFFFF_FFFF, 32'd0);
    XORF  = rq(OP_XOR, 1'b0, C_BEQ, 32'h0000_00F0, 32'h0000_000F);
    SUB   = rq(OP_ADD, 1'b1, C_BEQ, 32'd10, 32'd3);
    SLTU  = rq(OP_SLTU, 1'b0, C_BEQ, 32'd1, 32'd2);
    A11   = rq(OP_ADD, 1'b0, C_BEQ, 32'd1, 32'd1);
    A100  = rq(OP_ADD, 1'b0, C_BEQ, 32'd100, 32'd0);
    A34   = rq(OP_ADD, 1'b0, C_BEQ, 32'd3, 32'd4);
    A88   = rq(OP_ADD, 1'b0, C_BEQ, 32'd8, 32'd8);

    // single op, then response released
    add(2'b01, 2'b01, ADD57, NONE, 2'b01, 2'b00, 32'd0,  1'b0, 32'd5);
    add(2'b00, 2'b01, NONE,  NONE, 2'b00, 2'b01, 32'd12, 1'b0, 32'd0);
    add(2'b00, 2'b00, NONE,  NONE, 2'b00, 2'b00, 32'd12, 1'b0, 32'd0);
    // comparisons: BLT then BLTU back-to-back on req1
    add(2'b10, 2'b10, NONE, BLT,   2'b10, 2'b00, 32'd12, 1'b0, 32'hFFFF_FFFF);
    add(2'b10, 2'b10, NONE, BLTU,  2'b10, 2'b10, 32'd0,  1'b1, 32'hFFFF_FFFF);
    add(2'b00, 2'b10, NONE, NONE,  2'b00, 2'b10, 32'd0,  1'b0, 32'd0);
    add(2'b00, 2'b00, NONE, NONE,  2'b00, 2'b00, 32'd0,  1'b0, 32'd0);
    // back-pressure; non-owner ready is ignored; accept on release
    add(2'b01, 2'b00, ORF,  NONE,  2'b01, 2'b00, 32'd0,         1'b0, 32'hFFFF_FFFF);
    add(2'b10, 2'b00, NONE, XORF,  2'b00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'hF0);
    add(2'b10, 2'b10, NONE, XORF,  2'b00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'hF0);
    add(2'b10, 2'b00, NONE, XORF,  2'b00, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'hF0);
    add(2'b10, 2'b01, NONE, XORF,  2'b10, 2'b01, 32'hFFFF_FFFF, 1'b0, 32'hF0);
    add(2'b00, 2'b00, NONE, NONE,  2'b00, 2'b10, 32'hFF, 1'b0, 32'd0);
    add(2'b00, 2'b10, NONE, NONE,  2'b00, 2'b10, 32'hFF, 1'b0, 32'd0);
    add(2'b00, 2'b00, NONE, NONE,  2'b00, 2'b00, 32'hFF, 1'b0, 32'd0);
`ifdef ALU_ARB_RR_EN
    // contention: alternating grants, back-to-back responses
    add(2'b11, 2'b11, SUB, SLTU, 2'b01, 2'b00, 32'hFF, 1'b0, 32'd10);
    add(2'b11, 2'b11, SUB, SLTU, 2'b10, 2'b01, 32'd7,  1'b0, 32'd1);
    add(2'b11, 2'b11, SUB, SLTU, 2'b01, 2'b10, 32'd1,  1'b0, 32'd10);
    add(2'b10, 2'b11, SUB, SLTU, 2'b10, 2'b01, 32'd7,  1'b0, 32'd1);
    add(2'b00, 2'b11, NONE, NONE, 2'b00, 2'b10, 32'd1, 1'b0, 32'd0);
    add(2'b00, 2'b00, NONE, NONE, 2'b00, 2'b00, 32'd1, 1'b0, 32'd0);
`else
    // fixed priority: req0 always wins while valid
    add(2'b11, 2'b11, A11, A100, 2'b01, 2'b00, 32'hFF, 1'b0, 32'd1);
    add(2'b11, 2'b11, A11, A100, 2'b01, 2'b01, 32'd2,  1'b1, 32'd1);
    add(2'b11, 2'b11, A11, A100, 2'b01, 2'b01, 32'd2,  1'b1, 32'd1);
    add(2'b11, 2'b11, A11, A100, 2'b01, 2'b01, 32'd2,  1'b1, 32'd1);
    add(2'b10, 2'b11, A11, A100, 2'b10, 2'b01, 32'd2,  1'b1, 32'd100);
    add(2'b00, 2'b11, NONE, NONE, 2'b00, 2'b10, 32'd100, 1'b0, 32'd0);
    add(2'b00, 2'b00, NONE, NONE, 2'b00, 2'b00, 32'd100, 1'b0, 32'd0);
`endif

    // reset state
    drive(2'b00, 2'b00, NONE, NONE);
    repeat (2) @(negedge clk);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data",  rsp_data, 32'd0);
    chk("reset rsp_comp",  32'(rsp_comp), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("idle alu_a",      alu_a_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].rr, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].erdy));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].evld));
      chk($sformatf("row%0d rsp_data", i),  rsp_data, tbl[i].edata);
      chk($sformatf("row%0d rsp_comp", i),  32'(rsp_comp), 32'(tbl[i].ecomp));
      chk($sformatf("row%0d alu_a", i),     alu_a_data, tbl[i].ealu);
    end

    // reset while FULL discards the held response
    @(negedge clk);
    drive(2'b01, 2'b00, A34, NONE);
    #1 chk("rst seq accept", 32'(req_ready), 32'b01);
    @(negedge clk);
    drive(2'b00, 2'b00, NONE, NONE);
    #1 chk("rst seq held valid", 32'(rsp_valid), 32'b01);
    chk("rst seq held data", rsp_data, 32'd7);
    rst = 1'b1;
    #1 chk("async rst valid", 32'(rsp_valid), 32'd0);
    chk("async rst data", rsp_data, 32'd0);
    chk("async rst comp", 32'(rsp_comp), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive(2'b11, 2'b11, A34, A88);
    #1 chk("post rst first grant", 32'(req_ready), 32'b01);
    chk("post rst valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    drive(2'b10, 2'b11, A34, A88);
    #1 chk("post rst second grant", 32'(req_ready), 32'b10);
    chk("post rst rsp0 valid", 32'(rsp_valid), 32'b01);
    chk("post rst rsp0 data", rsp_data, 32'd7);
    @(negedge clk);
    drive(2'b00, 2'b11, NONE, NONE);
    #1 chk("post rst rsp1 valid", 32'(rsp_valid), 32'b10);
    chk("post rst rsp1 data", rsp_data, 32'd16);
    chk("post rst rsp1 comp", 32'(rsp_comp), 32'd1);
    @(negedge clk);
    drive(2'b00, 2'b00, NONE, NONE);
    #1 chk("post rst idle", 32'(rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
